// File: rtl/d_cond_pkg.sv
// Shared types and parameter checks for input-conditioning blocks.
// Sync chain plus debounce FSM encoding.
`ifndef D_COND_MACROS
`define D_COND_MACROS
`define D_COND_CHECK(lbl, cond, msg) \
  if (!(cond)) begin : lbl \
    $error(msg); \
  end
`endif

package d_cond_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } dstate_t;

  localparam int SYNC_MIN     = 2;
  localparam int DEBOUNCE_MIN = 1;

endpackage

// File: rtl/d_input_debouncer_if.sv
// Level input and conditioned outputs of the debouncer.
// master drives the raw level, slave is the debouncer.
interface d_input_debouncer_if;
  logic din_async;
  logic d_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (
    output din_async,
    input  d_out,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
  );

  modport slave (
    input  din_async,
    output d_out,
    output rise_pulse,
    output fall_pulse,
    output busy
  );
endinterface

// File: rtl/d_input_debouncer_sync.sv
// N-flop synchroniser for one asynchronous level.
// Chain clears to 0 and stays there while reset is held.
module sync_chain
  import d_cond_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  `D_COND_CHECK(g_bad_stages, STAGES >= SYNC_MIN,
                "sync_chain: STAGES must be >= 2")

  logic [STAGES-1:0] chain;

  // shift the raw level through the metastability chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/d_input_debouncer.sv
// Synchronise and debounce a level input into a clean D level.
// Emits one-cycle rise/fall pulses on each accepted change.
module d_input_debouncer
  import d_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  d_input_debouncer_if.slave   io
);

  `D_COND_CHECK(g_bad_sync, SYNC_STAGES >= SYNC_MIN,
                "d_input_debouncer: SYNC_STAGES must be >= 2")
  `D_COND_CHECK(g_bad_deb, DEBOUNCE_CYCLES >= DEBOUNCE_MIN,
                "d_input_debouncer: DEBOUNCE_CYCLES must be >= 1")

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s;
  logic             mismatch;
  dstate_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (io.din_async),
    .q   (s)
  );

  assign mismatch = s ^ dout_q;

  // state, counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // qualify a new level; accept only if it holds at the final edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mismatch) begin
          if (DEBOUNCE_CYCLES == 1) begin
            cnt_d  = '0;
            dout_d = s;
            rise_d = s;
            fall_d = ~s;
          end else begin
            cnt_d   = CNT_ONE;
            state_d = ST_CHECK;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_CHECK: begin
        if (mismatch && cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          dout_d  = s;
          rise_d  = s;
          fall_d  = ~s;
        end else if (mismatch) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign io.d_out      = dout_q;
  assign io.rise_pulse = rise_q;
  assign io.fall_pulse = fall_q;
  assign io.busy       = (state_q == ST_CHECK);

endmodule

// File: tb/tb_d_input_debouncer.sv
// Scoreboard bench for d_input_debouncer.
// Default instance plus a SYNC=3, DEBOUNCE=1 instance.
module tb_d_input_debouncer;

  typedef struct {
    logic rise;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t qa[$];
  exp_t qb[$];

  d_input_debouncer_if ifa();
  d_input_debouncer_if ifb();

  d_input_debouncer u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .io  (ifa)
  );

  d_input_debouncer #(
    .SYNC_STAGES     (3),
    .DEBOUNCE_CYCLES (1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .io  (ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor for the default instance
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0 && cyc > qa[0].cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL a_missed_pulse: got none expected at cycle %0d",
               qa[0].cyc);
      void'(qa.pop_front());
    end
    if (ifa.rise_pulse || ifa.fall_pulse) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_unexpected_pulse: got rise=%0b fall=%0b at %0d expected none",
                 ifa.rise_pulse, ifa.fall_pulse, cyc);
      end else begin
        e = qa.pop_front();
        check("a_pulse_cycle", cyc, e.cyc);
        check("a_rise", int'(ifa.rise_pulse), int'(e.rise));
        check("a_fall", int'(ifa.fall_pulse), int'(!e.rise));
        check("a_dout_at_pulse", int'(ifa.d_out), int'(e.rise));
      end
    end
  end

  // monitor for the fast instance
  always @(negedge clk) begin
    exp_t e;
    if (qb.size() > 0 && cyc > qb[0].cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL b_missed_pulse: got none expected at cycle %0d",
               qb[0].cyc);
      void'(qb.pop_front());
    end
    if (ifb.rise_pulse || ifb.fall_pulse) begin
      if (qb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_unexpected_pulse: got rise=%0b fall=%0b at %0d expected none",
                 ifb.rise_pulse, ifb.fall_pulse, cyc);
      end else begin
        e = qb.pop_front();
        check("b_pulse_cycle", cyc, e.cyc);
        check("b_rise", int'(ifb.rise_pulse), int'(e.rise));
        check("b_fall", int'(ifb.fall_pulse), int'(!e.rise));
        check("b_dout_at_pulse", int'(ifb.d_out), int'(e.rise));
      end
    end
  end

  initial begin
    int c0;
    int busy_n;
    int seen;

    // 1: reset with input high
    ifa.din_async = 1'b1;
    ifb.din_async = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t1_dout", int'(ifa.d_out), 0);
      check("t1_pulses", int'(ifa.rise_pulse | ifa.fall_pulse), 0);
      check("t1_busy", int'(ifa.busy), 0);
      check("t1_b_dout", int'(ifb.d_out), 0);
    end
    ifa.din_async = 1'b0;
    ifb.din_async = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("t1_dout_after_rel", int'(ifa.d_out), 0);

    // 2: clean rise, accept 5 edges after first sample
    ifa.din_async = 1'b1;
    c0 = cyc;
    qa.push_back('{rise: 1'b1, cyc: c0 + 6});
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifa.busy) busy_n++;
      if (cyc == c0 + 5)
        check("t2_dout_before", int'(ifa.d_out), 0);
    end
    check("t2_busy_cycles", busy_n, 3);
    check("t2_dout", int'(ifa.d_out), 1);

    // 3: glitch low for 30 ns is discarded
    @(negedge clk);
    ifa.din_async = 1'b0;
    repeat (3) @(negedge clk);
    ifa.din_async = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifa.busy) seen = 1;
    end
    check("t3_busy_seen", seen, 1);
    check("t3_busy_end", int'(ifa.busy), 0);
    check("t3_dout", int'(ifa.d_out), 1);

    // bring level back to 0 for the bounce test
    @(negedge clk);
    ifa.din_async = 1'b0;
    c0 = cyc;
    qa.push_back('{rise: 1'b0, cyc: c0 + 6});
    repeat (10) @(negedge clk);
    check("t3_fall_dout", int'(ifa.d_out), 0);

    // 4: bounce every 10 ns then settle high
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ifa.din_async = (i % 2 == 0);
    end
    @(negedge clk);
    ifa.din_async = 1'b1;
    c0 = cyc;
    qa.push_back('{rise: 1'b1, cyc: c0 + 6});
    repeat (10) @(negedge clk);
    check("t4_dout", int'(ifa.d_out), 1);

    // 5: fall interrupted by reset during qualification
    ifa.din_async = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_busy", int'(ifa.busy), 1);
    rst_a = 1'b0;
    #1;
    check("t5_dout_rst", int'(ifa.d_out), 0);
    check("t5_busy_rst", int'(ifa.busy), 0);
    check("t5_fall_rst", int'(ifa.fall_pulse), 0);
    @(negedge clk);
    rst_a = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_dout_after", int'(ifa.d_out), 0);
    check("t5_busy_after", int'(ifa.busy), 0);

    // 6: SYNC=3, DEBOUNCE=1 accepts 3 edges after first sample
    ifb.din_async = 1'b1;
    c0 = cyc;
    qb.push_back('{rise: 1'b1, cyc: c0 + 4});
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifb.busy) seen = 1;
      if (cyc == c0 + 3)
        check("t6_dout_before", int'(ifb.d_out), 0);
    end
    check("t6_busy_never", seen, 0);
    check("t6_dout", int'(ifb.d_out), 1);

    repeat (5) @(negedge clk);
    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
